// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
//   Routes one upstream valid/ready word stream to four downstream channels.
//   Each channel owns a single registered holding slot. A slot can be drained
//   and reloaded in the same cycle, so one channel can run at full rate.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   up_valid    : upstream word offered
//   up_ready    : word at up_sel can be taken this cycle (combinational)
//   up_sel      : destination channel 0..3
//   up_data     : upstream word
//   down_valid  : per-channel slot-full flags (registered)
//   down_ready  : per-channel consumer takes the held word
//   down_data0-3: held word of each channel (registered)
//   xfer_cnt    : count of accepted upstream words, wraps at 256

// One holding slot. A load has priority over a drain, so a drain and a load
// in the same cycle leave the slot full with the new word.
module demux_1_4_stream_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_drain,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            // data is left in place; only the valid flag is dropped
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

module demux_1_4_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [1:0]       up_sel,
    input  logic [WIDTH-1:0] up_data,
    output logic [3:0]       down_valid,
    input  logic [3:0]       down_ready,
    output logic [WIDTH-1:0] down_data0,
    output logic [WIDTH-1:0] down_data1,
    output logic [WIDTH-1:0] down_data2,
    output logic [WIDTH-1:0] down_data3,
    output logic [7:0]       xfer_cnt
);
    localparam int NUM_CH = 4;

    logic                          w_accept;
    logic [NUM_CH-1:0]             w_load;
    logic [NUM_CH-1:0]             w_drain;
    logic [NUM_CH-1:0]             w_valid;
    logic [NUM_CH-1:0][WIDTH-1:0]  w_data;
    logic [7:0]                    r_xfer_cnt;

    // Only the addressed channel can stall the input; a full slot is still
    // free if its consumer drains it this cycle.
    assign up_ready = !w_valid[up_sel] | down_ready[up_sel];
    assign w_accept = up_valid & up_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g]  = w_accept && (up_sel == 2'(g));
        assign w_drain[g] = w_valid[g] & down_ready[g];

        demux_1_4_stream_slot #(.WIDTH(WIDTH)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[g]),
            .i_data (up_data),
            .i_drain(w_drain[g]),
            .o_valid(w_valid[g]),
            .o_data (w_data[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_xfer_cnt <= 8'd0;
        else if (w_accept) r_xfer_cnt <= r_xfer_cnt + 8'd1;
    end

    assign down_valid = w_valid;
    assign down_data0 = w_data[0];
    assign down_data1 = w_data[1];
    assign down_data2 = w_data[2];
    assign down_data3 = w_data[3];
    assign xfer_cnt   = r_xfer_cnt;
endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: directed scenarios plus a long random run,
// all checked against a per-channel queue model of the holding slots.
module tb_demux_1_4_stream;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [1:0]   up_sel = 2'd0;
    logic [W-1:0] up_data = '0;
    logic [3:0]   down_valid;
    logic [3:0]   down_ready = 4'b0000;
    logic [W-1:0] down_data0, down_data1, down_data2, down_data3;
    logic [7:0]   xfer_cnt;

    int errors = 0;
    int checks = 0;

    demux_1_4_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_sel    (up_sel),
        .up_data   (up_data),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_data0(down_data0),
        .down_data1(down_data1),
        .down_data2(down_data2),
        .down_data3(down_data3),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Model: each channel is a queue of words accepted but not yet taken.
    logic [W-1:0] mq [4][$];
    int           total_acc;
    int           sent_n [4];
    int           deliv_n [4];
    logic         obs_rdy, exp_rdy;
    logic [3:0]   drn_flag;
    logic [W-1:0] drn_obs [4];
    logic [W-1:0] drn_exp [4];

    function automatic logic [W-1:0] dut_data(input int c);
        case (c)
            0: return down_data0;
            1: return down_data1;
            2: return down_data2;
            default: return down_data3;
        endcase
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (mq[c].size() != 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            sent_n[c]  = 0;
            deliv_n[c] = 0;
        end
        total_acc = 0;
    endtask

    // Drives one cycle (called one time unit after a rising edge), records
    // what the model expects to be taken/accepted, returns after the edge.
    task automatic apply(input logic v, input logic [1:0] s, input logic [3:0] dr,
                         input logic [W-1:0] d);
        up_valid = v; up_sel = s; down_ready = dr; up_data = d;
        #1;
        obs_rdy  = up_ready;
        exp_rdy  = (mq[s].size() == 0) || dr[s];
        drn_flag = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (mq[c].size() != 0 && dr[c]) begin
                drn_flag[c] = 1'b1;
                drn_obs[c]  = dut_data(c);
                drn_exp[c]  = mq[c].pop_front();
                deliv_n[c]++;
            end
        end
        if (v && exp_rdy) begin
            mq[s].push_back(d);
            sent_n[s]++;
            total_acc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; up_valid = 1'b0; down_ready = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        // power-on, before any clock edge
        #1;
        checks++; if (down_valid !== 4'b0000 || xfer_cnt !== 8'd0)
            begin errors++; $display("FAIL por: valid=%b cnt=%0d want 0000/0", down_valid, xfer_cnt); end
        checks++; if ({down_data0, down_data1, down_data2, down_data3} !== '0)
            begin errors++; $display("FAIL por_data: got %h want 0", {down_data0, down_data1, down_data2, down_data3}); end
        do_reset();
        for (int i = 0; i < 33; i++) apply(1'b1, 2'($urandom_range(0, 3)), 4'hf, W'($urandom));
        apply(1'b0, 2'd0, 4'hf, '0);
        for (int i = 0; i < 4; i++) apply(1'b1, 2'(i), 4'h0, W'(i + 5));
        checks++; if (down_valid !== 4'b1111 || xfer_cnt !== 8'd37)
            begin errors++; $display("FAIL reset_pre: valid=%b cnt=%0d want 1111/37", down_valid, xfer_cnt); end
        // asynchronous assert mid-cycle
        #3;
        rst = 1'b0; up_valid = 1'b1; up_sel = 2'd2; down_ready = 4'b0000;
        #1;
        checks++; if (down_valid !== 4'b0000 || xfer_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_async: valid=%b cnt=%0d want 0000/0", down_valid, xfer_cnt); end
        checks++; if ({down_data0, down_data1, down_data2, down_data3} !== '0)
            begin errors++; $display("FAIL reset_data: got %h want 0", {down_data0, down_data1, down_data2, down_data3}); end
        checks++; if (up_ready !== 1'b1)
            begin errors++; $display("FAIL reset_ready: got %b want 1", up_ready); end
        @(posedge clk); #1;
        checks++; if (down_valid !== 4'b0000 || xfer_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_hold: valid=%b cnt=%0d want 0000/0", down_valid, xfer_cnt); end
        rst = 1'b1;
        model_clear();
        apply(1'b1, 2'd1, 4'h0, 4'h9);
        checks++; if (down_valid !== 4'b0010 || down_data1 !== 4'h9 || xfer_cnt !== 8'd1)
            begin errors++; $display("FAIL first_accept: valid=%b d1=%h cnt=%0d want 0010/9/1", down_valid, down_data1, xfer_cnt); end
    endtask

    task automatic test_routing();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 2'(i), 4'h0, W'(i + 1));
            checks++; if (obs_rdy !== 1'b1)
                begin errors++; $display("FAIL route_rdy%0d: got %b want 1", i, obs_rdy); end
        end
        checks++; if (down_valid !== 4'b1111 || xfer_cnt !== 8'd4)
            begin errors++; $display("FAIL route_valid: valid=%b cnt=%0d want 1111/4", down_valid, xfer_cnt); end
        checks++; if ({down_data0, down_data1, down_data2, down_data3} !== 16'h1234)
            begin errors++; $display("FAIL route_data: got %h want 1234", {down_data0, down_data1, down_data2, down_data3}); end
    endtask

    task automatic test_backpressure();
        // continues from the four full slots left by test_routing
        apply(1'b1, 2'd2, 4'h0, 4'hA);
        checks++; if (obs_rdy !== 1'b0)
            begin errors++; $display("FAIL bp_rdy: got %b want 0", obs_rdy); end
        checks++; if (down_data2 !== 4'h3 || xfer_cnt !== 8'd4)
            begin errors++; $display("FAIL bp_hold: d2=%h cnt=%0d want 3/4", down_data2, xfer_cnt); end
        apply(1'b0, 2'd0, 4'b0010, '0);
        checks++; if (!drn_flag[1] || drn_obs[1] !== 4'h2 || down_valid !== 4'b1101)
            begin errors++; $display("FAIL bp_drain1: d=%h valid=%b want 2/1101", drn_obs[1], down_valid); end
        apply(1'b1, 2'd1, 4'h0, 4'hB);
        checks++; if (obs_rdy !== 1'b1 || down_data1 !== 4'hB || down_data2 !== 4'h3 || xfer_cnt !== 8'd5)
            begin errors++; $display("FAIL bp_other: rdy=%b d1=%h d2=%h cnt=%0d want 1/B/3/5", obs_rdy, down_data1, down_data2, xfer_cnt); end
        // drain and reload the same slot in one cycle
        apply(1'b1, 2'd1, 4'b0010, 4'hC);
        checks++; if (obs_rdy !== 1'b1 || drn_obs[1] !== 4'hB || down_data1 !== 4'hC || down_valid !== 4'b1111)
            begin errors++; $display("FAIL bp_swap: rdy=%b got=%h d1=%h valid=%b want 1/B/C/1111", obs_rdy, drn_obs[1], down_data1, down_valid); end
    endtask

    task automatic test_full_rate();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 2'd3, 4'hf, W'(i));
            checks++; if (obs_rdy !== 1'b1 || down_valid[3] !== 1'b1 || down_data3 !== W'(i))
                begin errors++; $display("FAIL full_rate%0d: rdy=%b v3=%b d3=%h want 1/1/%h", i, obs_rdy, down_valid[3], down_data3, W'(i)); end
            if (i > 0) begin
                checks++; if (drn_flag[3] !== 1'b1 || drn_obs[3] !== W'(i - 1))
                    begin errors++; $display("FAIL full_take%0d: got %h want %h", i, drn_obs[3], W'(i - 1)); end
            end
        end
        apply(1'b0, 2'd0, 4'hf, '0);
        checks++; if (drn_obs[3] !== 4'hF || down_valid !== 4'b0000 || deliv_n[3] != 16)
            begin errors++; $display("FAIL full_tail: got %h valid=%b n=%0d want F/0000/16", drn_obs[3], down_valid, deliv_n[3]); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) apply(1'b1, 2'($urandom_range(0, 3)), 4'hf, W'($urandom));
        checks++; if (xfer_cnt !== 8'd0)
            begin errors++; $display("FAIL wrap256: got %0d want 0", xfer_cnt); end
        apply(1'b1, 2'($urandom_range(0, 3)), 4'hf, W'($urandom));
        checks++; if (xfer_cnt !== 8'd1)
            begin errors++; $display("FAIL wrap257: got %0d want 1", xfer_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom), W'($urandom));
            checks++; if (obs_rdy !== exp_rdy)
                begin errors++; $display("FAIL rnd_rdy@%0d: got %b want %b", n, obs_rdy, exp_rdy); end
            for (int c = 0; c < 4; c++) begin
                if (drn_flag[c]) begin
                    checks++; if (drn_obs[c] !== drn_exp[c])
                        begin errors++; $display("FAIL rnd_take%0d@%0d: got %h want %h", c, n, drn_obs[c], drn_exp[c]); end
                end
                if (mq[c].size() != 0) begin
                    checks++; if (dut_data(c) !== mq[c][0])
                        begin errors++; $display("FAIL rnd_data%0d@%0d: got %h want %h", c, n, dut_data(c), mq[c][0]); end
                end
            end
            checks++; if (down_valid !== exp_valid() || xfer_cnt !== 8'(total_acc % 256))
                begin errors++; $display("FAIL rnd_state@%0d: valid=%b cnt=%0d want %b/%0d", n, down_valid, xfer_cnt, exp_valid(), total_acc % 256); end
        end
        for (int c = 0; c < 4; c++) begin
            checks++; if (sent_n[c] != deliv_n[c] + mq[c].size())
                begin errors++; $display("FAIL rnd_count%0d: sent %0d delivered %0d held %0d", c, sent_n[c], deliv_n[c], mq[c].size()); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_routing();
        test_backpressure();
        test_full_rate();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port up_valid, input, 1 bit: an upstream word is offered.
REQ-005 The block SHALL have port up_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-006 The block SHALL have port up_sel, input, 2 bits: destination channel (0..3) of the offered word.
REQ-007 The block SHALL have port up_data, input, WIDTH bits: the offered word.
REQ-008 The block SHALL have port down_valid, output, 4 bits: bit i means channel i holds a word.
REQ-009 The block SHALL have port down_ready, input, 4 bits: bit i means the channel i consumer takes the word.
REQ-010 The block SHALL have ports down_data0..down_data3, output, WIDTH bits each: the held word of channels 0..3.
REQ-011 The block SHALL have port xfer_cnt, output, 8 bits: count of accepted upstream words.

Function
REQ-012 Each channel i SHALL own one holding slot (valid_i, data_i), driving down_valid[i] and down_data_i directly from registers.
REQ-013 up_ready SHALL be combinational: up_ready = !down_valid[up_sel] | down_ready[up_sel], independent of up_valid.
REQ-014 An accept SHALL occur when up_valid & up_ready; at that edge slot up_sel loads up_data and sets valid.
REQ-015 Latency SHALL be exactly one cycle: a word accepted at edge N shows on down_valid/down_data of its channel from edge N onward.
REQ-016 A drain of channel i SHALL occur when down_valid[i] & down_ready[i]; with no same-cycle load of that slot, valid_i clears at that edge.
REQ-017 A simultaneous drain and accept on the same channel SHALL keep valid_i at 1 and replace data_i with the new word, so back-to-back full-rate flow is sustained.
REQ-018 Slots not addressed by up_sel SHALL be unaffected by an accept; drains on different channels in the same cycle SHALL all complete independently.
REQ-019 While down_valid[i]=1 and down_ready[i]=0, data_i SHALL hold stable.
REQ-020 A stalled channel SHALL block only words addressed to it; words for other channels SHALL still be accepted.
REQ-021 When up_valid=0, slot contents SHALL change only through drains.
REQ-022 xfer_cnt SHALL increment by 1 per accept and wrap modulo 256 (255 -> 0).
REQ-023 The block SHALL contain no other state; there is no FSM beyond the four valid bits and the counter.

Reset
REQ-024 When rst=0, the block SHALL immediately, without a clock, clear down_valid to 4'b0000, all down_data to 0, and xfer_cnt to 0.
REQ-025 Assertion of reset mid-operation SHALL discard every held word without delivering it; up_ready SHALL then evaluate to 1.
REQ-026 The first accept SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-027 Reset: rst=0 with slots full and xfer_cnt=37 -> down_valid=0, all data 0, xfer_cnt=0 before the next clk edge.
REQ-028 Routing: with down_ready=4'b0000, send words 0x1/0x2/0x3/0x4 to sel 0/1/2/3 on four consecutive cycles -> each is accepted, then down_valid=4'b1111, down_data0..3=1,2,3,4, and xfer_cnt=4.
REQ-029 Backpressure: channel 2 full, down_ready[2]=0, offer 0xA to sel 2 -> up_ready=0, no accept, down_data2 unchanged; offer 0xB to sel 1 -> accepted.
REQ-030 Full rate: down_ready=4'b1111, stream 16 words to sel 3 on consecutive cycles -> up_ready is constantly 1, each word appears one cycle after its accept, and no word is lost or duplicated.
REQ-031 Wrap: 256 accepts -> xfer_cnt returns to 0; 257 accepts -> xfer_cnt=1.
REQ-032 Random: random up_valid, up_sel, and down_ready over 10k cycles versus a per-channel queue scoreboard -> in-order delivery per channel, with no loss and no duplication.
